// File: rtl/rng_pkg.sv
// rng_pkg: shared LFSR constants and the arbiter state encoding for the RNG service.
package rng_pkg;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 8'h01;
  localparam int TAP_HI = 7;
  localparam int TAP_LO = 5;
  typedef enum logic [1:0] {IDLE, GRANT, STIR} state_t;
endpackage

// File: rtl/rng_lfsr.sv
// rng_lfsr: 8-bit Fibonacci LFSR (x^8 + x^6 + 1) with step and load enables.
// A load has priority over a step; a zero seed is replaced so the register cannot lock up.
module rng_lfsr
  import rng_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_data,
  output logic [LFSR_W-1:0] o_lfsr
);
  logic [LFSR_W-1:0] r_lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= LFSR_RESET;
    else if (i_load) r_lfsr <= (i_data == '0) ? LFSR_RESET : i_data;
    else if (i_step) r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[TAP_HI] ^ r_lfsr[TAP_LO]};
  end
  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin shared random-byte service; the LFSR is stirred STIR steps after each grant.
// Define RNG_SEED_EN to add the seed_we/seed_data load port.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int STIR    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [7:0]         rdata,
  output logic               rvalid,
  output logic               busy
`ifdef RNG_SEED_EN
  ,
  input  logic               seed_we,
  input  logic [7:0]         seed_data
`endif
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 4;
  state_t r_state, w_nxt;
  logic [PW-1:0] r_ptr, w_ptr, w_win;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt;
  logic [7:0] r_rdata, w_lfsr, w_seed;
  logic r_rvalid, r_busy, w_rvalid, w_step, w_found, w_load;
`ifdef RNG_SEED_EN
  assign w_load = seed_we;
  assign w_seed = seed_data;
`else
  assign w_load = 1'b0;
  assign w_seed = '0;
`endif
  rng_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .i_step(w_step),
    .i_load(w_load),
    .i_data(w_seed),
    .o_lfsr(w_lfsr)
  );
  // Scan downward so the set bit nearest to r_ptr (wrapping) is the last one written.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_ptr) + k) % NUM_REQ);
      end
  end
  always_comb begin
    w_nxt    = r_state;
    w_cnt    = r_cnt;
    w_ptr    = r_ptr;
    w_gnt    = '0;
    w_rvalid = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      IDLE: if (w_found) begin
        w_nxt    = GRANT;
        w_gnt    = NUM_REQ'(1) << w_win;
        w_rvalid = 1'b1;
        w_ptr    = PW'((int'(w_win) + 1) % NUM_REQ);
      end
      GRANT: begin
        w_nxt = rng_pkg::STIR;
        w_cnt = CW'(STIR - 1);
      end
      default: begin
        w_step = 1'b1;
        w_cnt  = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
        w_nxt  = (r_cnt == '0) ? IDLE : rng_pkg::STIR;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt;
      r_ptr    <= w_ptr;
      r_gnt    <= w_gnt;
      r_rvalid <= w_rvalid;
      r_busy   <= (w_nxt != IDLE);
      if (w_rvalid) r_rdata <= w_lfsr;
    end
  end
  assign gnt    = r_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign busy   = r_busy;
endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed and randomized checks of rng_arbiter at STIR=8 and STIR=1.
module tb_rng_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] req8 = '0, req1 = '0, gnt8, gnt1;
  logic [7:0] rd8, rd1;
  logic rv8, rv1, bz8, bz1;
`ifdef RNG_SEED_EN
  logic sw8 = 1'b0, sw1 = 1'b0;
  logic [7:0] sd8 = '0, sd1 = '0;
`endif
  int n_chk = 0, n_err = 0, cyc = 0;
  logic [7:0] exp_d[2];
  int last_g[2];
  int stir_of[2] = '{8, 1};
  always @(posedge clk) cyc <= cyc + 1;

  rng_arbiter #(.NUM_REQ(2), .STIR(8)) u8 (
    .clk(clk), .rst(rst), .req(req8), .gnt(gnt8), .rdata(rd8), .rvalid(rv8), .busy(bz8)
`ifdef RNG_SEED_EN
    , .seed_we(sw8), .seed_data(sd8)
`endif
  );
  rng_arbiter #(.NUM_REQ(2), .STIR(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .rdata(rd1), .rvalid(rv1), .busy(bz1)
`ifdef RNG_SEED_EN
    , .seed_we(sw1), .seed_data(sd1)
`endif
  );

  function automatic logic [7:0] nxt(input logic [7:0] x);
    int fb;
    fb = ((x / 128) + (x / 32)) % 2;
    return 8'((x * 2 + fb) % 256);
  endfunction
  function automatic logic [7:0] adv(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = nxt(y);
    return y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Raise r on instance s, wait for its grant, check it, then drop the granted bit.
  task automatic serve(input int s, input logic [1:0] r, input logic [1:0] eg, input bit gap);
    logic [1:0] g;
    if (s == 1) req1 = r; else req8 = r;
    g = '0;
    for (int t = 0; t < 60 && g == '0; t++) begin
      @(negedge clk);
      g = (s == 1) ? gnt1 : gnt8;
    end
    chk("gnt_seen", 32'(g != '0), 1);
    chk("gnt", g, eg);
    chk("rvalid", (s == 1) ? rv1 : rv8, 1);
    chk("rdata", (s == 1) ? rd1 : rd8, exp_d[s]);
    if (gap) chk("grant_gap", cyc - last_g[s], stir_of[s] + 2);
    last_g[s] = cyc;
    exp_d[s] = adv(exp_d[s], stir_of[s]);
    if (s == 1) req1 = req1 & ~g; else req8 = req8 & ~g;
  endtask

  initial begin
    logic [7:0] m_lfsr, ed;
    logic [1:0] r, eg;
    int m_ptr, m_wait, w;
    logic ev, eb;
    #12;
    chk("rst_gnt", gnt8, 0);
    chk("rst_rvalid", rv8, 0);
    chk("rst_rdata", rd8, 0);
    chk("rst_busy", bz8, 0);
    @(negedge clk) rst = 1'b0;
    exp_d = '{8'h01, 8'h01};
    last_g = '{0, 0};
    serve(0, 2'b01, 2'b01, 0);
    chk("busy_grant", bz8, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy_stir", bz8, 1);
      chk("rdata_hold", rd8, 8'h01);
      chk("rvalid_low", rv8, 0);
    end
    @(negedge clk);
    chk("busy_idle", bz8, 0);
    serve(0, 2'b01, 2'b01, 1);
    serve(1, 2'b01, 2'b01, 0);
    for (int i = 0; i < 3; i++) serve(1, 2'b01, 2'b01, 1);
    repeat (8) @(negedge clk);
    serve(0, 2'b01, 2'b01, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", gnt8, 0);
    chk("arst_rvalid", rv8, 0);
    chk("arst_rdata", rd8, 0);
    chk("arst_busy", bz8, 0);
    @(negedge clk) rst = 1'b0;
    req8 = '0;
    exp_d = '{8'h01, 8'h01};
    serve(0, 2'b11, 2'b01, 0);
    serve(0, 2'b11, 2'b10, 1);
    serve(0, 2'b11, 2'b01, 1);
    serve(0, 2'b11, 2'b10, 1);
    req8 = '0;
`ifdef RNG_SEED_EN
    repeat (4) @(negedge clk);
    sw1 = 1'b1; sd1 = 8'h20;
    @(negedge clk) sw1 = 1'b0;
    exp_d[1] = 8'h20;
    serve(1, 2'b01, 2'b01, 0);
    serve(1, 2'b01, 2'b01, 1);
    repeat (4) @(negedge clk);
    sw1 = 1'b1; sd1 = 8'h00;
    @(negedge clk) sw1 = 1'b0;
    exp_d[1] = 8'h01;
    serve(1, 2'b01, 2'b01, 0);
`endif
    // Randomized run on the STIR=8 instance against a countdown-based reference.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    req8 = '0;
    m_lfsr = 8'h01; m_ptr = 0; m_wait = 0;
    ed = 8'h00;
    for (int c = 0; c < 400; c++) begin
      r = req8 & ~gnt8;
      for (int b = 0; b < 2; b++)
        if (!r[b] && !gnt8[b] && $urandom_range(2) == 0) r[b] = 1'b1;
        else if (r[b] && $urandom_range(15) == 0) r[b] = 1'b0;
      req8 = r;
      if (m_wait == 0 && r != '0) begin
        w = r[m_ptr] ? m_ptr : 1 - m_ptr;
        eg = 2'(1 << w);
        ed = m_lfsr;
        ev = 1'b1;
        m_ptr = (w + 1) % 2;
        m_wait = 8 + 1;
      end else begin
        eg = '0;
        ev = 1'b0;
        if (m_wait > 0) begin
          if (m_wait <= 8) m_lfsr = nxt(m_lfsr);
          m_wait--;
        end
      end
      eb = (m_wait != 0);
      @(negedge clk);
      chk("rnd_gnt", gnt8, eg);
      chk("rnd_rvalid", rv8, ev);
      chk("rnd_rdata", rd8, ed);
      chk("rnd_busy", bz8, eb);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
